// File: rtl/csr_trap_if.sv
// Handshake and result bundle between the system-op classifier and csr_trap_unit.
// master drives ops in; slave returns CSR read data, redirect and mstatus.MIE.
interface csr_trap_if #(
  parameter int XLEN = 64
);
  logic            valid_in;
  logic            ready_out;
  logic [4:0]      cause_in;
  logic [XLEN-1:0] tval_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] wdata_in;
  logic [XLEN-1:0] rdata_out;
  logic            rdata_valid;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            mie_out;

  modport master (
    output valid_in, cause_in, tval_in,
    output pc_in, wdata_in,
    input  ready_out, rdata_out, rdata_valid,
    input  redirect, redirect_pc, mie_out
  );

  modport slave (
    input  valid_in, cause_in, tval_in,
    input  pc_in, wdata_in,
    output ready_out, rdata_out, rdata_valid,
    output redirect, redirect_pc, mie_out
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with CSR RMW, trap entry, mret and fetch redirect.
// Optional minstret/instret counter and retire port: define CSR_MINSTRET_EN.
module csr_trap_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input logic       clk,
  input logic       rst,
`ifdef CSR_MINSTRET_EN
  input logic       retire,
`endif
  csr_trap_if.slave bus
);

  localparam logic [4:0] SYSOP_CSR_W  = 5'd24;
  localparam logic [4:0] SYSOP_CSR_S  = 5'd25;
  localparam logic [4:0] SYSOP_CSR_C  = 5'd26;
  localparam logic [4:0] SYSOP_ECALL  = 5'd27;
  localparam logic [4:0] SYSOP_EBREAK = 5'd28;
  localparam logic [4:0] SYSOP_RET    = 5'd29;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
`ifdef CSR_MINSTRET_EN
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_CSR, S_TRAP, S_RET
  } state_t;

  state_t r_state, w_next;

  logic [4:0]      r_cause;
  logic [XLEN-1:0] r_tval, r_pc, r_wdata;
  logic            r_ill;
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc;
  logic [XLEN-1:0] r_mcause, r_mtval, r_mcycle;
`ifdef CSR_MINSTRET_EN
  logic [XLEN-1:0] r_minstret;
`endif

  logic            w_accept, w_csr_in;
  logic [11:0]     w_addr;
  logic [XLEN-1:0] w_rd, w_new;
  logic            w_impl, w_wr, w_ill, w_we;
  logic [XLEN-1:0] w_tcause, w_ttval;
  logic            w_rv, w_redir;

  assign w_csr_in = (bus.cause_in == SYSOP_CSR_W)
                  | (bus.cause_in == SYSOP_CSR_S)
                  | (bus.cause_in == SYSOP_CSR_C);
  assign w_accept = bus.valid_in & (r_state == S_IDLE)
                  & (bus.cause_in != 5'd0);
  assign w_addr   = r_tval[11:0];

  always_comb begin
    w_rd   = '0;
    w_impl = 1'b1;
    unique case (w_addr)
      A_MSTATUS: begin
        w_rd[12:11] = 2'b11;
        w_rd[7]     = r_mpie;
        w_rd[3]     = r_mie;
      end
      A_MTVEC:            w_rd = r_mtvec;
      A_MSCRATCH:         w_rd = r_mscratch;
      A_MEPC:             w_rd = r_mepc;
      A_MCAUSE:           w_rd = r_mcause;
      A_MTVAL:            w_rd = r_mtval;
      A_MCYCLE, A_CYCLE:  w_rd = r_mcycle;
`ifdef CSR_MINSTRET_EN
      A_MINSTRET,
      A_INSTRET:          w_rd = r_minstret;
`endif
      default:            w_impl = 1'b0;
    endcase
  end

  // S/C with a zero operand is a pure read, so it may target read-only aliases
  assign w_wr  = (r_cause == SYSOP_CSR_W) | (r_wdata != '0);
  assign w_ill = ~w_impl | ((w_addr[11:10] == 2'b11) & w_wr);
  assign w_we  = (r_state == S_CSR) & ~w_ill & w_wr;

  always_comb begin
    w_new = w_rd;
    unique case (r_cause)
      SYSOP_CSR_W: w_new = r_wdata;
      SYSOP_CSR_S: w_new = w_rd | r_wdata;
      SYSOP_CSR_C: w_new = w_rd & ~r_wdata;
      default:     w_new = w_rd;
    endcase
  end

  always_comb begin
    w_tcause = XLEN'(r_cause);
    w_ttval  = r_tval;
    unique case (1'b1)
      r_ill: begin
        w_tcause = XLEN'(2);
        w_ttval  = XLEN'(w_addr);
      end
      (r_cause == SYSOP_ECALL): begin
        w_tcause = XLEN'(11);
        w_ttval  = '0;
      end
      (r_cause == SYSOP_EBREAK): begin
        w_tcause = XLEN'(3);
        w_ttval  = r_pc;
      end
      default: begin
        w_tcause = XLEN'(r_cause);
        w_ttval  = r_tval;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_csr_in)                         w_next = S_CSR;
          else if (bus.cause_in == SYSOP_RET)   w_next = S_RET;
          else                                  w_next = S_TRAP;
        end
      end
      S_CSR:   w_next = w_ill ? S_TRAP : S_IDLE;
      S_TRAP:  w_next = S_IDLE;
      S_RET:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause    <= '0;
      r_tval     <= '0;
      r_pc       <= '0;
      r_wdata    <= '0;
      r_ill      <= 1'b0;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_VEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcycle   <= '0;
`ifdef CSR_MINSTRET_EN
      r_minstret <= '0;
`endif
    end else begin
      r_mcycle <= r_mcycle + 1'b1;
`ifdef CSR_MINSTRET_EN
      if (retire) r_minstret <= r_minstret + 1'b1;
`endif
      if (w_accept) begin
        r_cause <= bus.cause_in;
        r_tval  <= bus.tval_in;
        r_pc    <= bus.pc_in;
        r_wdata <= bus.wdata_in;
        r_ill   <= 1'b0;
      end
      if ((r_state == S_CSR) && w_ill) r_ill <= 1'b1;
      if (w_we) begin
        unique case (w_addr)
          A_MSTATUS: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          A_MTVEC:    r_mtvec    <= w_new;
          A_MSCRATCH: r_mscratch <= w_new;
          A_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
          A_MCAUSE:   r_mcause   <= w_new;
          A_MTVAL:    r_mtval    <= w_new;
          A_MCYCLE:   r_mcycle   <= w_new;
`ifdef CSR_MINSTRET_EN
          A_MINSTRET: r_minstret <= w_new;
`endif
          default:    ;
        endcase
      end
      if (r_state == S_TRAP) begin
        r_mepc   <= {r_pc[XLEN-1:2], 2'b00};
        r_mcause <= w_tcause;
        r_mtval  <= w_ttval;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end
      if (r_state == S_RET) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

  // rst gates the pulses so an op caught by reset never escapes
  assign w_rv  = (r_state == S_CSR) & ~w_ill & ~rst;
  assign w_redir = ((r_state == S_TRAP) | (r_state == S_RET)) & ~rst;

  assign bus.ready_out   = (r_state == S_IDLE);
  assign bus.rdata_valid = w_rv;
  assign bus.rdata_out   = w_rv ? w_rd : '0;
  assign bus.redirect    = w_redir;
  assign bus.redirect_pc = ~w_redir ? '0 :
                           (r_state == S_TRAP) ?
                           {r_mtvec[XLEN-1:2], 2'b00} : r_mepc;
  assign bus.mie_out     = r_mie;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios then random ops
// checked against a behavioural CSR model.
module tb_csr_trap_unit;

  localparam logic [4:0] OP_W   = 5'd24;
  localparam logic [4:0] OP_S   = 5'd25;
  localparam logic [4:0] OP_C   = 5'd26;
  localparam logic [4:0] OP_EC  = 5'd27;
  localparam logic [4:0] OP_EB  = 5'd28;
  localparam logic [4:0] OP_RET = 5'd29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_trap_if #(.XLEN(64)) bus();

`ifdef CSR_MINSTRET_EN
  logic retire = 1'b0;
`endif

  csr_trap_unit #(
    .XLEN(64),
    .RESET_VEC(64'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CSR_MINSTRET_EN
    .retire(retire),
`endif
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] m_mtvec, m_mscratch, m_mepc;
  logic [63:0] m_mcause, m_mtval, m_off;
  bit          m_mie, m_mpie;
`ifdef CSR_MINSTRET_EN
  logic [63:0] m_minstret;
`endif

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // mcycle is modelled as an offset from the bench's edge count
  function automatic void m_reset();
    m_mtvec = 64'h0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0;
    m_mie = 0; m_mpie = 0;
    m_off = 64'h0 - cyc;
`ifdef CSR_MINSTRET_EN
    m_minstret = 0;
`endif
  endfunction

  function automatic void m_read(input logic [11:0] a,
                                 output logic [63:0] v,
                                 output bit impl);
    impl = 1;
    v = 0;
    case (a)
      12'h300: v = 64'h1800 | (64'(m_mpie) << 7)
                            | (64'(m_mie) << 3);
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00, 12'hC00: v = m_off + cyc;
`ifdef CSR_MINSTRET_EN
      12'hB02, 12'hC02: v = m_minstret;
`endif
      default: impl = 0;
    endcase
  endfunction

  function automatic void m_write(input logic [11:0] a,
                                  input logic [63:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h305: m_mtvec = v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~64'h3;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      12'hB00: m_off = v - cyc;
`ifdef CSR_MINSTRET_EN
      12'hB02: m_minstret = v;
`endif
      default: ;
    endcase
  endfunction

  task automatic trap_step(input logic [63:0] mc,
                           input logic [63:0] tv,
                           input logic [63:0] pc);
    check("redirect", 64'(bus.redirect), 64'd1);
    check("trap_pc", bus.redirect_pc, m_mtvec & ~64'h3);
    check("rdv_trap", 64'(bus.rdata_valid), 64'd0);
    m_mepc = pc & ~64'h3;
    m_mcause = mc;
    m_mtval = tv;
    m_mpie = m_mie;
    m_mie = 0;
    @(posedge clk); #1;
    check("redirect_end", 64'(bus.redirect), 64'd0);
    check("ready_after_trap", 64'(bus.ready_out), 64'd1);
  endtask

  task automatic run_op(input logic [4:0] c,
                        input logic [63:0] tv,
                        input logic [63:0] pc,
                        input logic [63:0] wd);
    logic [63:0] old, nv;
    logic [11:0] a;
    bit impl, wr, ill;
    int n;
    n = 0;
    while (!bus.ready_out && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before", 64'(bus.ready_out), 64'd1);
    @(negedge clk);
    bus.valid_in = 1; bus.cause_in = c;
    bus.tval_in = tv; bus.pc_in = pc; bus.wdata_in = wd;
    @(posedge clk); #1;
    bus.valid_in = 0;
    check("busy", 64'(bus.ready_out), 64'd0);
    if (c == OP_W || c == OP_S || c == OP_C) begin
      a = tv[11:0];
      m_read(a, old, impl);
      wr = (c == OP_W) || (wd != 0);
      ill = !impl || (a[11:10] == 2'b11 && wr);
      check("rdata_valid", 64'(bus.rdata_valid), 64'(!ill));
      if (!ill) begin
        check("rdata", bus.rdata_out, old);
        nv = (c == OP_W) ? wd :
             (c == OP_S) ? (old | wd) : (old & ~wd);
        @(posedge clk); #1;
        if (wr) m_write(a, nv);
        check("ready_after_csr", 64'(bus.ready_out), 64'd1);
      end else begin
        check("redirect_early", 64'(bus.redirect), 64'd0);
        @(posedge clk); #1;
        trap_step(64'd2, 64'(a), pc);
      end
    end else if (c == OP_RET) begin
      check("ret_redirect", 64'(bus.redirect), 64'd1);
      check("ret_pc", bus.redirect_pc, m_mepc);
      m_mie = m_mpie;
      m_mpie = 1;
      @(posedge clk); #1;
      check("ret_end", 64'(bus.redirect), 64'd0);
      check("ready_after_ret", 64'(bus.ready_out), 64'd1);
    end else if (c == OP_EC) begin
      trap_step(64'd11, 64'd0, pc);
    end else if (c == OP_EB) begin
      trap_step(64'd3, pc, pc);
    end else begin
      trap_step(64'(c), tv, pc);
    end
    check("mie", 64'(bus.mie_out), 64'(m_mie));
  endtask

  task automatic do_reset();
    rst = 1;
    bus.valid_in = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_reset();
  endtask

  task automatic rd(input logic [11:0] a);
    run_op(OP_S, 64'(a), 64'h40, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] addrs [12];
    logic [63:0] x, prev, wd, pc;
    logic [4:0]  c;
    int k;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h343, 12'hB00, 12'hC00,
              12'h7FF, 12'hB02, 12'hC02, 12'h301};
    bus.valid_in = 0; bus.cause_in = 0;
    bus.tval_in = 0; bus.pc_in = 0; bus.wdata_in = 0;
    do_reset();

    check("rst_ready", 64'(bus.ready_out), 64'd1);
    check("rst_rdv", 64'(bus.rdata_valid), 64'd0);
    check("rst_redir", 64'(bus.redirect), 64'd0);
    check("rst_rdata", bus.rdata_out, 64'd0);
    check("rst_rpc", bus.redirect_pc, 64'd0);
    check("rst_mie", 64'(bus.mie_out), 64'd0);
    rd(12'h300);
    rd(12'h305);

    run_op(OP_W, 64'h340, 64'h100, 64'hDEAD_BEEF);
    rd(12'h340);
    rd(12'h340);

    run_op(OP_W, 64'h305, 64'h104, 64'h8000_0100);
    run_op(OP_S, 64'h300, 64'h108, 64'h8);
    check("mie_set", 64'(bus.mie_out), 64'd1);
    run_op(OP_EC, 64'h0, 64'h1000, 64'h0);
    rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300);
    run_op(OP_RET, 64'h0, 64'h2000, 64'h0);
    check("mie_ret", 64'(bus.mie_out), 64'd1);
    rd(12'h300);

    run_op(OP_W, 64'h7FF, 64'h3000, 64'h5);
    rd(12'h342); rd(12'h343);
    run_op(OP_W, 64'hC00, 64'h3004, 64'h5);
    rd(12'h342); rd(12'h343);
    run_op(OP_EB, 64'h0, 64'h4006, 64'h0);
    run_op(5'd5, 64'hABCD, 64'h5000, 64'h0);
    rd(12'h343);

    run_op(OP_W, 64'hB00, 64'h6000, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    run_op(OP_S, 64'hB00, 64'h6004, 64'h0);
    rd(12'hC00);

    // valid_in with no event is ignored
    @(negedge clk);
    bus.valid_in = 1; bus.cause_in = 0;
    @(posedge clk); #1;
    bus.valid_in = 0;
    check("idle_ready", 64'(bus.ready_out), 64'd1);
    check("idle_rdv", 64'(bus.rdata_valid), 64'd0);
    check("idle_redir", 64'(bus.redirect), 64'd0);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 8);
      wd = ($urandom_range(0, 3) == 0) ? 64'd0
           : {$urandom, $urandom};
      pc = {$urandom, $urandom};
      if (k <= 4) begin
        c = (k < 2) ? OP_W : (k < 4) ? OP_S : OP_C;
        run_op(c, 64'(addrs[$urandom_range(0, 11)]), pc, wd);
      end else if (k == 5) begin
        run_op(OP_EC, 64'h0, pc, 64'h0);
      end else if (k == 6) begin
        run_op(OP_EB, 64'h0, pc, 64'h0);
      end else if (k == 7) begin
        run_op(OP_RET, 64'h0, pc, 64'h0);
      end else begin
        run_op(5'($urandom_range(1, 23)),
               {$urandom, $urandom}, pc, 64'h0);
      end
    end

    // back-pressure: second op waits for ready_out
    x = {$urandom, $urandom} | 64'h1;
    prev = m_mscratch;
    @(negedge clk);
    bus.valid_in = 1; bus.cause_in = OP_W;
    bus.tval_in = 64'h340; bus.wdata_in = x;
    @(posedge clk); #1;
    bus.cause_in = OP_S; bus.wdata_in = 0;
    check("bp_rdv0", 64'(bus.rdata_valid), 64'd1);
    check("bp_rd0", bus.rdata_out, prev);
    check("bp_busy", 64'(bus.ready_out), 64'd0);
    @(posedge clk); #1;
    m_mscratch = x;
    check("bp_rdv1", 64'(bus.rdata_valid), 64'd0);
    check("bp_ready1", 64'(bus.ready_out), 64'd1);
    @(posedge clk); #1;
    bus.valid_in = 0;
    check("bp_rdv2", 64'(bus.rdata_valid), 64'd1);
    check("bp_rd2", bus.rdata_out, x);
    @(posedge clk); #1;
    check("bp_rdv3", 64'(bus.rdata_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_rdv4", 64'(bus.rdata_valid), 64'd0);

    // reset lands while the unit is in TRAP
    run_op(OP_W, 64'h305, 64'h0, 64'h1234_5670);
    @(negedge clk);
    bus.valid_in = 1; bus.cause_in = OP_EC; bus.pc_in = 64'h9000;
    @(posedge clk); #1;
    bus.valid_in = 0;
    rst = 1;
    #1;
    check("rst_trap_redir", 64'(bus.redirect), 64'd0);
    @(posedge clk); #1;
    check("rst_trap_redir2", 64'(bus.redirect), 64'd0);
    check("rst_trap_ready", 64'(bus.ready_out), 64'd1);
    @(posedge clk);
    #1 rst = 0;
    m_reset();
    rd(12'h305);
    rd(12'h342);
    rd(12'hB00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
